// File: rtl/regfile_check_pkg.sv
// Shared definitions for the register-file self-check sequencer:
// FSM state encoding, default widths and the check-table entry type.
package regfile_check_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_MAX_CHECKS = 16;
    localparam int DEF_IDX_W      = 4;
    localparam int DEF_CYC_W      = 16;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_ISSUE   = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // One table entry: which register to read and the value it should hold.
    typedef struct packed {
        logic [DEF_REG_ADDR_W-1:0] reg_addr;
        logic [DEF_DATA_W-1:0]     value;
    } check_entry_t;

endpackage

// File: rtl/regfile_check_sequencer_if.sv
// Regfile read-port A as seen by the check sequencer. The sequencer is the
// master (drives test mux select and address), the skeleton regfile is the
// slave (returns read data combinationally).
interface regfile_check_sequencer_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  test;
    logic [REG_ADDR_W-1:0] ctrl_readRegA;
    logic [DATA_W-1:0]     data_readRegA;

    modport master (
        output test,
        output ctrl_readRegA,
        input  data_readRegA
    );

    modport slave (
        input  test,
        input  ctrl_readRegA,
        output data_readRegA
    );
endinterface

// File: rtl/regfile_check_table.sv
// Check table: MAX_CHECKS entries of (register, expected value) held in
// flops, one synchronous write port and one combinational read port.
module regfile_check_table #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_CHECKS = 16,
    parameter int IDX_W      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [REG_ADDR_W-1:0] wr_reg,
    input  logic [DATA_W-1:0]     wr_value,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [REG_ADDR_W-1:0] rd_reg,
    output logic [DATA_W-1:0]     rd_value
);

    logic [REG_ADDR_W-1:0] reg_mem [MAX_CHECKS];
    logic [DATA_W-1:0]     val_mem [MAX_CHECKS];

    // Entry storage: cleared on reset, written one entry per cycle when enabled.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MAX_CHECKS; i++) begin
                reg_mem[i] <= '0;
                val_mem[i] <= '0;
            end
        end else if (wr_en) begin
            reg_mem[wr_idx] <= wr_reg;
            val_mem[wr_idx] <= wr_value;
        end
    end

    assign rd_reg   = reg_mem[rd_idx];
    assign rd_value = val_mem[rd_idx];

endmodule

// File: rtl/regfile_check_sequencer.sv
// Register-file self-check engine. After start it lets the skeleton run for
// a programmed number of cycles, then takes over regfile read port A and
// walks the check table, tallying matches and mismatches.
// Optional feature macro: REGFILE_CHECK_FAIL_CAPTURE_EN (records index and
// read data of the first mismatch of a run; ports tie to 0 otherwise).
module regfile_check_sequencer
    import regfile_check_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int MAX_CHECKS = DEF_MAX_CHECKS,
    parameter int IDX_W      = DEF_IDX_W,
    parameter int CYC_W      = DEF_CYC_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [CYC_W-1:0]      run_cycles,
    input  logic [IDX_W:0]        num_checks,
    input  logic                  load_en,
    input  logic [IDX_W-1:0]      load_idx,
    input  logic [REG_ADDR_W-1:0] load_reg,
    input  logic [DATA_W-1:0]     load_value,
    regfile_check_sequencer_if.master rf,
    output logic                  busy,
    output logic                  done,
    output logic [IDX_W:0]        pass_count,
    output logic [IDX_W:0]        fail_count,
    output logic                  all_pass,
    output logic [IDX_W-1:0]      first_fail_idx,
    output logic [DATA_W-1:0]     first_fail_actual
);

    localparam logic [IDX_W:0] MAX_CHECKS_V = (IDX_W+1)'(MAX_CHECKS);

    state_t                state;
    state_t                state_next;
    logic [CYC_W-1:0]      cyc_cnt;
    logic [CYC_W-1:0]      run_len;
    logic [IDX_W:0]        check_len;
    logic [IDX_W:0]        num_checks_clamped;
    logic [IDX_W-1:0]      idx;
    logic [REG_ADDR_W-1:0] entry_reg;
    logic [DATA_W-1:0]     entry_value;
    logic                  idle_or_done;
    logic                  start_ok;
    logic                  run_last;
    logic                  cmp_last;
    logic                  match;
    logic                  test_c;
    logic [REG_ADDR_W-1:0] addr_c;

    assign num_checks_clamped = (num_checks > MAX_CHECKS_V) ? MAX_CHECKS_V : num_checks;
    assign idle_or_done       = (state == ST_IDLE) || (state == ST_DONE);
    assign start_ok           = start && idle_or_done;
    assign run_last           = (run_len == '0) || (cyc_cnt == run_len - 1'b1);
    assign cmp_last           = ({1'b0, idx} == check_len - 1'b1);
    assign match              = (rf.data_readRegA == entry_value);

    regfile_check_table #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .MAX_CHECKS (MAX_CHECKS),
        .IDX_W      (IDX_W)
    ) u_table (
        .clock    (clock),
        .reset    (reset),
        .wr_en    (load_en && idle_or_done),
        .wr_idx   (load_idx),
        .wr_reg   (load_reg),
        .wr_value (load_value),
        .rd_idx   (idx),
        .rd_reg   (entry_reg),
        .rd_value (entry_value)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and state-decoded outputs; the address is held through COMPARE so read data is stable.
    always_comb begin
        state_next = state;
        test_c     = 1'b0;
        addr_c     = '0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start_ok) state_next = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (run_last) state_next = ST_SETTLE;
            end
            ST_SETTLE: begin
                busy       = 1'b1;
                test_c     = 1'b1;
                state_next = (check_len == '0) ? ST_DONE : ST_ISSUE;
            end
            ST_ISSUE: begin
                busy       = 1'b1;
                test_c     = 1'b1;
                addr_c     = entry_reg;
                state_next = ST_COMPARE;
            end
            ST_COMPARE: begin
                busy       = 1'b1;
                test_c     = 1'b1;
                addr_c     = entry_reg;
                state_next = cmp_last ? ST_DONE : ST_ISSUE;
            end
            ST_DONE: begin
                test_c = 1'b1;
                done   = 1'b1;
                if (start_ok) state_next = ST_RUN;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rf.test          = test_c;
    assign rf.ctrl_readRegA = addr_c;
    assign all_pass         = done && (fail_count == '0);

    // Run counter, latched run parameters, table index and pass/fail tallies.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cyc_cnt    <= '0;
            run_len    <= '0;
            check_len  <= '0;
            idx        <= '0;
            pass_count <= '0;
            fail_count <= '0;
        end else if (start_ok) begin
            cyc_cnt    <= '0;
            run_len    <= run_cycles;
            check_len  <= num_checks_clamped;
            idx        <= '0;
            pass_count <= '0;
            fail_count <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    cyc_cnt <= cyc_cnt + 1'b1;
                end
                ST_SETTLE: begin
                    idx <= '0;
                end
                ST_COMPARE: begin
                    if (match) pass_count <= pass_count + 1'b1;
                    else       fail_count <= fail_count + 1'b1;
                    if (!cmp_last) idx <= idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef REGFILE_CHECK_FAIL_CAPTURE_EN
    // First-mismatch capture: the tally is still zero exactly on the first failing compare.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            first_fail_idx    <= '0;
            first_fail_actual <= '0;
        end else if (start_ok) begin
            first_fail_idx    <= '0;
            first_fail_actual <= '0;
        end else if ((state == ST_COMPARE) && !match && (fail_count == '0)) begin
            first_fail_idx    <= idx;
            first_fail_actual <= rf.data_readRegA;
        end
    end
`else
    assign first_fail_idx    = '0;
    assign first_fail_actual = '0;
`endif

endmodule

// File: tb/tb_regfile_check_sequencer.sv
// Self-checking bench for regfile_check_sequencer: a fixed vector table for
// the basic scenarios, hand sequences for reset/ignore/clamp corners, and a
// randomized loop checked against a behavioural model of the check run.
module tb_regfile_check_sequencer;
    import regfile_check_pkg::*;

    localparam int MAX_CHECKS = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] run_cycles = '0;
    logic [4:0]  num_checks = '0;
    logic        load_en = 1'b0;
    logic [3:0]  load_idx = '0;
    logic [4:0]  load_reg = '0;
    logic [31:0] load_value = '0;
    logic        busy;
    logic        done;
    logic [4:0]  pass_count;
    logic [4:0]  fail_count;
    logic        all_pass;
    logic [3:0]  first_fail_idx;
    logic [31:0] first_fail_actual;

    regfile_check_sequencer_if #(.DATA_W(32), .REG_ADDR_W(5)) rf_if ();

    logic [31:0]  regs [32];
    check_entry_t model_tbl [MAX_CHECKS];

    int          total = 0;
    int          bad = 0;
    int          exp_pass;
    int          exp_fail;
    int          exp_lat;
    int          exp_ffi;
    logic [31:0] exp_ffa;

    typedef struct {
        int          run;
        int          n;
        bit          r2_bad;
        int          lat;
        int          pass;
        int          fail;
        bit          allp;
        int          ffi;
        logic [31:0] ffa;
    } vec_t;

    vec_t vecs [5];

    assign rf_if.data_readRegA = regs[rf_if.ctrl_readRegA];

    regfile_check_sequencer dut (
        .clock             (clock),
        .reset             (reset),
        .start             (start),
        .run_cycles        (run_cycles),
        .num_checks        (num_checks),
        .load_en           (load_en),
        .load_idx          (load_idx),
        .load_reg          (load_reg),
        .load_value        (load_value),
        .rf                (rf_if),
        .busy              (busy),
        .done              (done),
        .pass_count        (pass_count),
        .fail_count        (fail_count),
        .all_pass          (all_pass),
        .first_fail_idx    (first_fail_idx),
        .first_fail_actual (first_fail_actual)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic clearModel();
        for (int i = 0; i < MAX_CHECKS; i++) model_tbl[i] = '0;
    endtask

    task automatic loadEntry(input int idx, input int r, input logic [31:0] v);
        @(negedge clock);
        load_en    = 1'b1;
        load_idx   = 4'(idx);
        load_reg   = 5'(r);
        load_value = v;
        @(posedge clock);
        #1;
        load_en = 1'b0;
        model_tbl[idx] = '{reg_addr: 5'(r), value: v};
    endtask

    task automatic loadBaseTable();
        loadEntry(0, 1, 32'd65535);
        loadEntry(1, 2, 32'd7);
        loadEntry(2, 3, 32'd0);
    endtask

    // Pulse start (optionally with a same-cycle table write); returns 1ns after the sampling edge.
    task automatic applyStimulus(input int run, input int n, input bit with_load,
                                 input int lidx, input int lreg, input logic [31:0] lval);
        @(negedge clock);
        start      = 1'b1;
        run_cycles = 16'(run);
        num_checks = 5'(n);
        if (with_load) begin
            load_en    = 1'b1;
            load_idx   = 4'(lidx);
            load_reg   = 5'(lreg);
            load_value = lval;
            model_tbl[lidx] = '{reg_addr: 5'(lreg), value: lval};
        end
        @(posedge clock);
        #1;
        start   = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic waitDone(input int budget, output int cycles, output bit addr_moved);
        cycles     = 0;
        addr_moved = 1'b0;
        while (!done && cycles < budget) begin
            @(posedge clock);
            #1;
            cycles++;
            if (rf_if.ctrl_readRegA != 5'd0) addr_moved = 1'b1;
        end
        checkOutput("done_reached", done, 1);
    endtask

    // Expected outcome of a run from the table contents and the regfile image.
    task automatic computeModel(input int run, input int n);
        int lim;
        bit seen;
        logic [31:0] actual;
        lim      = (n > MAX_CHECKS) ? MAX_CHECKS : n;
        seen     = 1'b0;
        exp_pass = 0;
        exp_fail = 0;
        exp_ffi  = 0;
        exp_ffa  = '0;
        for (int i = 0; i < lim; i++) begin
            actual = regs[model_tbl[i].reg_addr];
            if (actual == model_tbl[i].value) begin
                exp_pass++;
            end else begin
                exp_fail++;
                if (!seen) begin
                    seen    = 1'b1;
                    exp_ffi = i;
                    exp_ffa = actual;
                end
            end
        end
        exp_lat = ((run == 0) ? 1 : run) + 1 + 2 * lim;
    endtask

    task automatic checkRun(input string tag, input int cycles, input int lat, input int pass,
                            input int fail, input bit allp, input int ffi, input logic [31:0] ffa);
        checkOutput({tag, "_latency"}, cycles, lat);
        checkOutput({tag, "_pass"}, pass_count, pass);
        checkOutput({tag, "_fail"}, fail_count, fail);
        checkOutput({tag, "_all_pass"}, all_pass, allp);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_test"}, rf_if.test, 1);
`ifdef REGFILE_CHECK_FAIL_CAPTURE_EN
        checkOutput({tag, "_ff_idx"}, first_fail_idx, ffi);
        checkOutput({tag, "_ff_actual"}, first_fail_actual, ffa);
`else
        checkOutput({tag, "_ff_idx"}, first_fail_idx, 0);
        checkOutput({tag, "_ff_actual"}, first_fail_actual, 0);
        if (ffi < 0 || ffa === 'x) $display("[TB] note: unexpected model capture value");
`endif
    endtask

    initial begin
        int cyc;
        int cyc_b;
        bit moved;
        int run;
        int n;
        int nloads;

        vecs[0] = '{run: 10, n: 3, r2_bad: 1'b0, lat: 17, pass: 3, fail: 0, allp: 1'b1, ffi: 0, ffa: 32'd0};
        vecs[1] = '{run: 10, n: 3, r2_bad: 1'b1, lat: 17, pass: 2, fail: 1, allp: 1'b0, ffi: 1, ffa: 32'd8};
        vecs[2] = '{run: 5,  n: 0, r2_bad: 1'b0, lat: 6,  pass: 0, fail: 0, allp: 1'b1, ffi: 0, ffa: 32'd0};
        vecs[3] = '{run: 1,  n: 1, r2_bad: 1'b1, lat: 4,  pass: 1, fail: 0, allp: 1'b1, ffi: 0, ffa: 32'd0};
        vecs[4] = '{run: 3,  n: 2, r2_bad: 1'b1, lat: 8,  pass: 1, fail: 1, allp: 1'b0, ffi: 1, ffa: 32'd8};

        for (int i = 0; i < 32; i++) regs[i] = $urandom;
        regs[0] = 32'd0;
        regs[1] = 32'd65535;
        regs[2] = 32'd7;
        regs[3] = 32'd0;
        clearModel();

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        checkOutput("rst_test", rf_if.test, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_all_pass", all_pass, 0);
        checkOutput("rst_pass", pass_count, 0);
        checkOutput("rst_fail", fail_count, 0);
        checkOutput("rst_addr", rf_if.ctrl_readRegA, 0);
        checkOutput("rst_ff_idx", first_fail_idx, 0);
        checkOutput("rst_ff_actual", first_fail_actual, 0);
        @(negedge clock);
        reset = 1'b0;

        // Table-driven scenarios on the base table
        loadBaseTable();
        for (int v = 0; v < 5; v++) begin
            regs[2] = vecs[v].r2_bad ? 32'd8 : 32'd7;
            applyStimulus(vecs[v].run, vecs[v].n, 1'b0, 0, 0, 32'd0);
            waitDone(200, cyc, moved);
            checkRun($sformatf("vec%0d", v), cyc, vecs[v].lat, vecs[v].pass, vecs[v].fail,
                     vecs[v].allp, vecs[v].ffi, vecs[v].ffa);
            if (vecs[v].n == 0) checkOutput("vec_addr_quiet", moved, 0);
        end

        // Reset during COMPARE of entry 1, then a clean rerun
        regs[2] = 32'd7;
        applyStimulus(2, 3, 1'b0, 0, 0, 32'd0);
        repeat (6) @(posedge clock);
        #1;
        checkOutput("mid_busy", busy, 1);
        checkOutput("mid_pass", pass_count, 1);
        checkOutput("mid_addr", rf_if.ctrl_readRegA, 2);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("arst_test", rf_if.test, 0);
        checkOutput("arst_busy", busy, 0);
        checkOutput("arst_pass", pass_count, 0);
        checkOutput("arst_fail", fail_count, 0);
        checkOutput("arst_done", done, 0);
        @(negedge clock);
        reset = 1'b0;
        clearModel();
        loadBaseTable();
        applyStimulus(10, 3, 1'b0, 0, 0, 32'd0);
        waitDone(200, cyc, moved);
        checkRun("rerun", cyc, 17, 3, 0, 1'b1, 0, 32'd0);

        // start and load_en during RUN are ignored
        applyStimulus(10, 3, 1'b0, 0, 0, 32'd0);
        repeat (3) @(posedge clock);
        @(negedge clock);
        start      = 1'b1;
        run_cycles = 16'd2;
        num_checks = 5'd1;
        load_en    = 1'b1;
        load_idx   = 4'd0;
        load_reg   = 5'd1;
        load_value = 32'd5;
        @(posedge clock);
        #1;
        start   = 1'b0;
        load_en = 1'b0;
        waitDone(200, cyc_b, moved);
        checkRun("ignore", cyc_b + 4, 17, 3, 0, 1'b1, 0, 32'd0);
        applyStimulus(1, 1, 1'b0, 0, 0, 32'd0);
        waitDone(200, cyc, moved);
        checkRun("ignore_tbl", cyc, 4, 1, 0, 1'b1, 0, 32'd0);

        // num_checks above table depth clamps
        for (int i = 0; i < MAX_CHECKS; i++) loadEntry(i, i + 1, regs[i + 1]);
        applyStimulus(3, MAX_CHECKS + 3, 1'b0, 0, 0, 32'd0);
        waitDone(200, cyc, moved);
        checkRun("clamp", cyc, 36, 16, 0, 1'b1, 0, 32'd0);

        // Randomized runs against the behavioural model
        for (int k = 0; k < 25; k++) begin
            nloads = $urandom_range(0, 3);
            for (int j = 0; j < nloads; j++)
                loadEntry($urandom_range(0, 15), $urandom_range(0, 31), 32'($urandom_range(0, 3)));
            for (int r = 0; r < 32; r++) regs[r] = 32'($urandom_range(0, 3));
            run = $urandom_range(0, 6);
            n   = $urandom_range(0, 20);
            applyStimulus(run, n, 1'($urandom_range(0, 1)), $urandom_range(0, 15),
                          $urandom_range(0, 31), 32'($urandom_range(0, 3)));
            computeModel(run, n);
            waitDone(200, cyc, moved);
            checkRun($sformatf("rand%0d", k), cyc, exp_lat, exp_pass, exp_fail,
                     (exp_fail == 0), exp_ffi, exp_ffa);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
